mips_dmem_responder: RTL

- Multicycle data-memory responder for the MIPS CPU's load/store port; the CPU is the initiator.
- Accepts one MemRead or MemWrite request at a time, inserts a programmable number of wait states, then returns a one-cycle ready pulse, with ReadData for loads.
- Word-addressed storage; detects misaligned, out-of-range and conflicting requests and reports them with an error flag.
- Sits between the CPU datapath and memory, so the CPU can be exercised against non-ideal memory timing.

---
 rtl/mips_dmem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - multicycle MIPS data-memory responder with wait states and error reporting
module mips_dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ready,
    output logic                  busy,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    req;
    logic                    req_err;
    logic                    do_access;
    logic                    access_write;
    logic [ADDR_WIDTH-1:0]   mem_idx;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_we;

    assign req     = MemRead | MemWrite;
    assign req_err = (MemRead & MemWrite)
                   | (Address[1:0] != 2'b00)
                   | ((Address >> (ADDR_WIDTH + 2)) != 32'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        ready_d      = 1'b0;
        error_d      = 1'b0;
        rdata_d      = '0;
        do_access    = 1'b0;
        access_write = is_write_q;
        mem_idx      = idx_q;
        mem_wdata    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d      = Address[ADDR_WIDTH+1:2];
                    wdata_d    = WriteData;
                    is_write_d = MemWrite;
                    if (req_err) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access uses the live request this edge.
                        state_d      = ST_RESP;
                        ready_d      = 1'b1;
                        do_access    = 1'b1;
                        access_write = MemWrite;
                        mem_idx      = Address[ADDR_WIDTH+1:2];
                        mem_wdata    = WriteData;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_RESP;
                    ready_d   = 1'b1;
                    do_access = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access && !access_write) begin
            rdata_d = mem[mem_idx];
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Reset takes priority over a commit landing on the same edge.
    assign mem_we = do_access & access_write & ~reset;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
        end
    end

    assign ReadData = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule
